// File: rtl/nic_pkg.sv
// Shared NIC port constants and poll-sequencer state encoding.
package nic_pkg;

  localparam logic [1:0] NIC_ADDR_IBUF  = 2'b00;
  localparam logic [1:0] NIC_ADDR_ISTAT = 2'b01;
  localparam logic [1:0] NIC_ADDR_OBUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OSTAT = 2'b11;

  localparam int NIC_STAT_FULL_BIT = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OST_RD,
    ST_OST_CHK,
    ST_OBUF_WR,
    ST_IST_RD,
    ST_IST_CHK,
    ST_IBUF_RD,
    ST_IBUF_CAP,
    ST_GAP
  } poll_state_e;

endpackage

// File: rtl/nic_rr_arb2.sv
// Two-requester round-robin: on a tie, grant the side that was not served last.
module nic_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req_tx_i,
  input  logic req_rx_i,
  input  logic upd_vld_i,
  input  logic upd_tx_i,
  output logic gnt_tx_o,
  output logic gnt_rx_o
);

  logic last_tx_q;

  // Resets to "RX served last" so TX wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_tx_q <= 1'b0;
    end else if (upd_vld_i) begin
      last_tx_q <= upd_tx_i;
    end
  end

  always_comb begin
    gnt_tx_o = req_tx_i && (!req_rx_i || !last_tx_q);
    gnt_rx_o = req_rx_i && (!req_tx_i || last_tx_q);
  end

endmodule

// File: rtl/nic_poll_ctrl.sv
// Polls cardinal_nic status and moves TX/RX stream words through its buffers,
// round-robin between the two directions.
module nic_poll_ctrl
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  parameter int POLL_GAP   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_en,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_ready,
  output logic [1:0]            nic_addr,
  output logic [DATA_WIDTH-1:0] nic_d_in,
  output logic                  nic_en,
  output logic                  nic_en_wr,
  input  logic [DATA_WIDTH-1:0] nic_d_out,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic [CNT_WIDTH-1:0]  rx_count
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

  poll_state_e           state_q;
  logic [GAP_W-1:0]      gap_q;
  logic                  rx_valid_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic [CNT_WIDTH-1:0]  tx_cnt_q;
  logic [CNT_WIDTH-1:0]  rx_cnt_q;

  logic stat_full;
  logic req_tx, req_rx, gnt_tx, gnt_rx;
  logic upd_vld, upd_tx;

  assign stat_full = nic_d_out[NIC_STAT_FULL_BIT];

  // RX is eligible when the holding register is empty or drains this cycle.
  assign req_tx = (state_q == ST_IDLE) && ctrl_en && tx_valid;
  assign req_rx = (state_q == ST_IDLE) && ctrl_en && (!rx_valid_q || rx_ready);

  assign upd_vld = ((state_q == ST_OST_CHK) && stat_full) || (state_q == ST_OBUF_WR) ||
                   (state_q == ST_IST_CHK && !stat_full) || (state_q == ST_IBUF_CAP);
  assign upd_tx  = (state_q == ST_OST_CHK) || (state_q == ST_OBUF_WR);

  nic_rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_tx_i  (req_tx),
    .req_rx_i  (req_rx),
    .upd_vld_i (upd_vld),
    .upd_tx_i  (upd_tx),
    .gnt_tx_o  (gnt_tx),
    .gnt_rx_o  (gnt_rx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_tx)      state_q <= ST_OST_RD;
          else if (gnt_rx) state_q <= ST_IST_RD;
        end
        ST_OST_RD:  state_q <= ST_OST_CHK;
        ST_OST_CHK: state_q <= stat_full ? ST_IDLE : ST_OBUF_WR;
        ST_OBUF_WR: begin
          if (tx_valid) tx_cnt_q <= tx_cnt_q + CNT_WIDTH'(1);
          state_q <= ST_IDLE;
        end
        ST_IST_RD:  state_q <= ST_IST_CHK;
        ST_IST_CHK: begin
          if (stat_full) begin
            state_q <= ST_IBUF_RD;
          end else if (POLL_GAP > 0) begin
            state_q <= ST_GAP;
            gap_q   <= GAP_W'(POLL_GAP);
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_IBUF_RD: state_q <= ST_IBUF_CAP;
        ST_IBUF_CAP: begin
          rx_data_q  <= nic_d_out;
          rx_valid_q <= 1'b1;
          rx_cnt_q   <= rx_cnt_q + CNT_WIDTH'(1);
          state_q    <= ST_IDLE;
        end
        ST_GAP: begin
          // A waiting TX word cuts the back-off short.
          if (tx_valid || gap_q == GAP_W'(1) || gap_q == '0) state_q <= ST_IDLE;
          else                                              gap_q   <= gap_q - GAP_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    nic_en    = 1'b0;
    nic_en_wr = 1'b0;
    nic_addr  = NIC_ADDR_IBUF;
    nic_d_in  = '0;
    tx_ready  = 1'b0;
    case (state_q)
      ST_OST_RD: begin
        nic_en   = 1'b1;
        nic_addr = NIC_ADDR_OSTAT;
      end
      ST_OBUF_WR: begin
        // A withdrawn word must not turn into a store.
        if (tx_valid) begin
          nic_en    = 1'b1;
          nic_en_wr = 1'b1;
          nic_addr  = NIC_ADDR_OBUF;
          nic_d_in  = tx_data;
          tx_ready  = 1'b1;
        end
      end
      ST_IST_RD: begin
        nic_en   = 1'b1;
        nic_addr = NIC_ADDR_ISTAT;
      end
      ST_IBUF_RD: begin
        nic_en   = 1'b1;
        nic_addr = NIC_ADDR_IBUF;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign tx_count = tx_cnt_q;
  assign rx_count = rx_cnt_q;

endmodule

// File: tb/tb_nic_poll_ctrl.sv
// Directed bench for nic_poll_ctrl with a behavioural cardinal_nic processor port.
module tb_nic_poll_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ctrl_en;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [63:0] rx_data;
  logic        rx_ready;
  logic [1:0]  nic_addr;
  logic [63:0] nic_d_in;
  logic        nic_en;
  logic        nic_en_wr;
  logic [63:0] nic_d_out;
  logic        busy;
  logic [15:0] tx_count;
  logic [15:0] rx_count;

  always #5 clk = ~clk;

  nic_poll_ctrl #(.DATA_WIDTH(64), .CNT_WIDTH(16), .POLL_GAP(3)) dut (
    .clk(clk), .reset(reset), .ctrl_en(ctrl_en),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_en(nic_en), .nic_en_wr(nic_en_wr),
    .nic_d_out(nic_d_out), .busy(busy), .tx_count(tx_count), .rx_count(rx_count)
  );

  // NIC model: one OUT buffer drained to the network when net_ro=1, one IN buffer.
  logic        out_full_m = 1'b0, in_full_m = 1'b0;
  logic [63:0] in_data_m = '0, out_word_m = '0, sent_word = '0;
  int          sent_cnt = 0;
  int          wr_cnt = 0;
  int          rd_cnt [4] = '{default: 0};
  logic        inj_req = 1'b0;
  logic [63:0] inj_data = '0;
  logic        net_ro = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      out_full_m <= 1'b0;
      in_full_m  <= 1'b0;
      nic_d_out  <= '0;
    end else begin
      if (nic_en && !nic_en_wr) begin
        rd_cnt[nic_addr] <= rd_cnt[nic_addr] + 1;
        case (nic_addr)
          2'b00: begin nic_d_out <= in_data_m; in_full_m <= 1'b0; end
          2'b01: nic_d_out <= {63'b0, in_full_m};
          2'b11: nic_d_out <= {63'b0, out_full_m};
          default: nic_d_out <= '0;
        endcase
      end
      if (nic_en && nic_en_wr && nic_addr == 2'b10) begin
        wr_cnt     <= wr_cnt + 1;
        out_full_m <= 1'b1;
        out_word_m <= nic_d_in;
      end else if (net_ro && out_full_m) begin
        out_full_m <= 1'b0;
        sent_word  <= out_word_m;
        sent_cnt   <= sent_cnt + 1;
      end
      if (inj_req) begin
        in_full_m <= 1'b1;
        in_data_m <= inj_data;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic inject(input logic [63:0] d);
    inj_data = d;
    inj_req  = 1'b1;
    step();
    inj_req  = 1'b0;
  endtask

  // Holds tx_valid until a tx_ready is seen, then releases it after that edge.
  task automatic do_tx(input logic [63:0] d, input int bound, input string tag);
    bit seen;
    seen     = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < bound && !seen; i++) begin
      step();
      if (tx_ready === 1'b1) seen = 1'b1;
    end
    if (seen) step();
    tx_valid = 1'b0;
    chk(tag, 64'(seen), 64'd1);
  endtask

  initial begin
    int base_a, base_b, k1, k2, rdy_hits;
    bit seen;

    reset = 1'b1; ctrl_en = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    chk("reset busy",     64'(busy),     64'd0);
    chk("reset tx_ready", 64'(tx_ready), 64'd0);
    chk("reset rx_valid", 64'(rx_valid), 64'd0);
    chk("reset rx_data",  rx_data,       64'd0);
    chk("reset counts",   {tx_count, rx_count}, 64'd0);
    chk("reset nic_en",   64'(nic_en),   64'd0);

    // Single store, OUT empty: 11 poll, then 10 write in the 3rd cycle.
    ctrl_en = 1'b1; net_ro = 1'b1; tx_valid = 1'b1; tx_data = 64'h0BAD_F00D_0BAD_F00D;
    step();
    chk("t1 ostat poll", {62'b0, nic_addr} | (64'(nic_en) << 8) | (64'(nic_en_wr) << 9), 64'h103);
    step();
    chk("t1 chk idle bus", 64'(nic_en), 64'd0);
    step();
    chk("t1 tx_ready",  64'(tx_ready), 64'd1);
    chk("t1 obuf wr",   {62'b0, nic_addr} | (64'(nic_en) << 8) | (64'(nic_en_wr) << 9), 64'h302);
    chk("t1 d_in",      nic_d_in, 64'h0BAD_F00D_0BAD_F00D);
    step();
    tx_valid = 1'b0;
    chk("t1 tx_count",  64'(tx_count), 64'd1);
    repeat (3) step();
    chk("t1 sent word", sent_word, 64'h0BAD_F00D_0BAD_F00D);

    // OUT stays full while the network stalls: second word must not be stored.
    net_ro = 1'b0;
    do_tx(64'h1234_5678_9ABC_DEF0, 30, "t2 first store");
    chk("t2 tx_count a", 64'(tx_count), 64'd2);
    base_a = rd_cnt[3];
    tx_data = 64'hFACE_FACE_FACE_FACE; tx_valid = 1'b1;
    rdy_hits = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tx_ready === 1'b1) rdy_hits++;
    end
    chk("t2 no ready while full", 64'(rdy_hits), 64'd0);
    chk("t2 repeated polls", 64'(rd_cnt[3] - base_a >= 2), 64'd1);
    chk("t2 tx_count held", 64'(tx_count), 64'd2);
    net_ro = 1'b1;
    do_tx(64'hFACE_FACE_FACE_FACE, 30, "t2 store after drain");
    chk("t2 tx_count b", 64'(tx_count), 64'd3);
    repeat (3) step();
    chk("t2 sent word", sent_word, 64'hFACE_FACE_FACE_FACE);
    chk("t2 writes", 64'(wr_cnt), 64'd3);

    // RX capture with consumer stalled, then release.
    inject(64'hABCD_EF00_FEDC_BA00);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (rx_valid === 1'b1) seen = 1'b1;
    end
    chk("t3 rx_valid", 64'(seen), 64'd1);
    chk("t3 rx_data", rx_data, 64'hABCD_EF00_FEDC_BA00);
    chk("t3 rx_count", 64'(rx_count), 64'd1);
    base_a = rd_cnt[0]; base_b = rd_cnt[1];
    repeat (15) step();
    chk("t3 no in access", 64'((rd_cnt[0] - base_a) + (rd_cnt[1] - base_b)), 64'd0);
    chk("t3 rx held", 64'(rx_valid), 64'd1);
    rx_ready = 1'b1;
    step();
    chk("t3 rx cleared", 64'(rx_valid), 64'd0);

    // Both pending at once: TX first, then RX.
    ctrl_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (busy === 1'b0) seen = 1'b1;
    end
    chk("t4 drain to idle", 64'(seen), 64'd1);
    inject(64'h7777_0000_7777_0000);
    tx_data = 64'h5555_AAAA_5555_AAAA; tx_valid = 1'b1;
    ctrl_en = 1'b1;
    step();
    chk("t4 tx first", {62'b0, nic_addr} | (64'(nic_en) << 8), 64'h103);
    step(); step();
    chk("t4 tx_ready", 64'(tx_ready), 64'd1);
    step();
    chk("t4 tx_count", 64'(tx_count), 64'd4);
    step();
    chk("t4 rx second", {62'b0, nic_addr} | (64'(nic_en) << 8), 64'h101);
    tx_valid = 1'b0;
    step(); step();
    chk("t4 ibuf rd", {62'b0, nic_addr} | (64'(nic_en) << 8), 64'h100);
    step(); step();
    chk("t4 rx_valid", 64'(rx_valid), 64'd1);
    chk("t4 rx_data", rx_data, 64'h7777_0000_7777_0000);
    chk("t4 rx_count", 64'(rx_count), 64'd2);

    // Empty IN: status polls recur every 6 cycles (RD, CHK, 3 GAP, IDLE).
    k1 = -1; k2 = -1;
    for (int i = 0; i < 20 && k1 < 0; i++) begin
      step();
      if (nic_en === 1'b1 && nic_addr === 2'b01) k1 = i;
    end
    for (int i = k1 + 1; i < k1 + 21 && k2 < 0 && k1 >= 0; i++) begin
      step();
      if (nic_en === 1'b1 && nic_addr === 2'b01) k2 = i;
    end
    chk("t5 poll period", 64'(k2 - k1), 64'd6);
    step(); step();
    tx_data = 64'h9999_9999_9999_9999; tx_valid = 1'b1;
    step();
    chk("t5 gap exit idle", 64'(busy), 64'd0);
    step();
    chk("t5 ostat after gap", {62'b0, nic_addr} | (64'(nic_en) << 8), 64'h103);
    do_tx(64'h9999_9999_9999_9999, 10, "t5 store");
    chk("t5 tx_count", 64'(tx_count), 64'd5);

    // Word withdrawn in the write state: no store issued.
    base_a = wr_cnt;
    tx_data = 64'hDEAD_DEAD_DEAD_DEAD; tx_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (tx_ready === 1'b1) seen = 1'b1;
    end
    tx_valid = 1'b0;
    #1;
    chk("t6 drop ready", 64'(tx_ready), 64'd0);
    chk("t6 drop nic_en", 64'(nic_en), 64'd0);
    step();
    chk("t6 drop count", 64'(tx_count), 64'd5);
    chk("t6 drop writes", 64'(wr_cnt - base_a), 64'd0);

    // Reset landing in the write state.
    base_a = wr_cnt;
    tx_data = 64'hAAAA_BBBB_CCCC_DDDD; tx_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (tx_ready === 1'b1) seen = 1'b1;
    end
    chk("t7 reached obuf_wr", 64'(seen), 64'd1);
    reset = 1'b1;
    step();
    chk("t7 busy",   64'(busy), 64'd0);
    chk("t7 outs",   {61'b0, tx_ready, nic_en, nic_en_wr}, 64'd0);
    chk("t7 counts", {tx_count, rx_count}, 64'd0);
    chk("t7 rx",     {rx_data[62:0], rx_valid}, 64'd0);
    chk("t7 no write", 64'(wr_cnt - base_a), 64'd0);
    reset = 1'b0; tx_valid = 1'b0;

    // Reset landing in the capture state.
    inject(64'hBBBB_0000_BBBB_0000);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (nic_en === 1'b1 && nic_addr === 2'b00) seen = 1'b1;
    end
    chk("t8 reached ibuf_rd", 64'(seen), 64'd1);
    step();
    reset = 1'b1;
    step();
    chk("t8 rx_valid", 64'(rx_valid), 64'd0);
    chk("t8 rx_count", 64'(rx_count), 64'd0);
    chk("t8 busy",     64'(busy), 64'd0);
    reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
